// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, default widths and HALT word for the imem RAM and decoder
package imem_pkg;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} imem_state_t;
  localparam int DEF_INST_W = 9;
  localparam int DEF_PC_W = 8;
  localparam logic [DEF_INST_W-1:0] DEF_HALT_WORD = '1;
endpackage

// File: rtl/imem_array.sv
// imem_array: clocked single-port RAM with registered read data
module imem_array #(
  parameter int W = 9,
  parameter int AW = 8,
  parameter int DEPTH = 256
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);
  localparam int AB = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr[AB-1:0]] <= i_wdata;
    else if (i_re) r_rdata <= r_mem[i_addr[AB-1:0]];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/imem_ram.sv
// imem_ram: loadable instruction memory (clear -> stream load -> registered fetch)
// Optional even-parity protection per word when IMEM_PARITY_EN is defined.
module imem_ram
  import imem_pkg::*;
#(
  parameter int INST_W = DEF_INST_W,
  parameter int PC_W = DEF_PC_W,
  parameter int DEPTH = 256,
  parameter logic [INST_W-1:0] HALT_WORD = '1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [PC_W-1:0]   i_pc,
  input  logic              i_fetch_en,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  input  logic              i_ld_valid,
  input  logic [INST_W-1:0] i_ld_data,
  input  logic              i_ld_last,
  output logic              o_ld_ready,
  output logic [PC_W:0]     o_ld_count,
  output logic              o_ld_ovf,
  output logic              o_run,
  output logic              o_parity_err
);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = INST_W + 1;
`else
  localparam int MEM_W = INST_W;
`endif
  localparam logic [PC_W:0] DEPTH_C = (PC_W+1)'(DEPTH);
  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(DEPTH - 1);
  imem_state_t r_state, w_next;
  logic [PC_W-1:0] r_clr_addr;
  logic [PC_W:0] r_ld_count;
  logic r_ld_ovf, r_inst_valid, r_oor;
  logic w_accept, w_room, w_we, w_re;
  logic [PC_W-1:0] w_addr;
  logic [INST_W-1:0] w_wd_raw;
  logic [MEM_W-1:0] w_wdata, w_rdata;
  assign w_room = r_ld_count < DEPTH_C;
  assign w_accept = r_state == LOAD && i_ld_valid;
  assign w_we = r_state == CLEAR || (w_accept && w_room);
  assign w_re = r_state == RUN && i_fetch_en;
  assign w_addr = r_state == CLEAR ? r_clr_addr : r_state == LOAD ? r_ld_count[PC_W-1:0] : i_pc;
  assign w_wd_raw = r_state == CLEAR ? HALT_WORD : i_ld_data;
`ifdef IMEM_PARITY_EN
  assign w_wdata = {^w_wd_raw, w_wd_raw};
`else
  assign w_wdata = w_wd_raw;
`endif
  imem_array #(.W(MEM_W), .AW(PC_W), .DEPTH(DEPTH)) u_arr (
    .i_clk(i_clk), .i_we(w_we), .i_re(w_re), .i_addr(w_addr),
    .i_wdata(w_wdata), .o_rdata(w_rdata)
  );
  always_comb begin
    w_next = r_state;
    if (r_state == CLEAR && r_clr_addr == LAST_ADDR) w_next = LOAD;
    if (w_accept && i_ld_last) w_next = RUN;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= CLEAR;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clr_addr <= '0;
      r_ld_count <= '0;
      r_ld_ovf <= 1'b0;
      r_inst_valid <= 1'b0;
      r_oor <= 1'b0;
    end else begin
      if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      if (w_accept && w_room) r_ld_count <= r_ld_count + 1'b1;
      if (w_accept && !w_room) r_ld_ovf <= 1'b1;
      if (w_re) begin
        r_inst_valid <= 1'b1;
        r_oor <= {1'b0, i_pc} >= DEPTH_C;
      end
    end
  end
  assign o_inst = r_inst_valid && !r_oor ? w_rdata[INST_W-1:0] : HALT_WORD;
  assign o_inst_valid = r_inst_valid;
  assign o_ld_ready = r_state == LOAD;
  assign o_ld_count = r_ld_count;
  assign o_ld_ovf = r_ld_ovf;
  assign o_run = r_state == RUN;
`ifdef IMEM_PARITY_EN
  // Error is visible alongside the faulty inst, then held sticky.
  logic r_fetched, r_perr, w_perr_now;
  assign w_perr_now = r_fetched && !r_oor && ^w_rdata;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetched <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_fetched <= w_re;
      r_perr <= r_perr | w_perr_now;
    end
  end
  assign o_parity_err = r_perr | w_perr_now;
`else
  assign o_parity_err = 1'b0;
`endif
endmodule
